// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit owning the HI/LO pair, with Busy for hazard stalls.
// Multiply-accumulate ops (6-9) exist only when MULDIV_MADD_EN is defined; otherwise they are no-ops.
module muldiv_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0]    MULT_LAT = CW'(MULT_CYCLES);
  localparam logic [CW-1:0]    DIV_LAT  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0]    LAST     = CW'(1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
`ifdef MULDIV_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;

  localparam logic [1:0] MODE_SET = 2'd0;
  localparam logic [1:0] MODE_ADD = 2'd1;
  localparam logic [1:0] MODE_SUB = 2'd2;

  logic [1:0] pend_mode;
  logic [1:0] launch_mode;
`endif

  logic [0:0]         state;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   pend_hi;
  logic [WIDTH-1:0]   pend_lo;
  logic               pend_write;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic [2*WIDTH-1:0] result;
  logic               signed_div;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   b_safe;
  logic [WIDTH-1:0]   q_mag;
  logic [WIDTH-1:0]   r_mag;
  logic [WIDTH-1:0]   div_q;
  logic [WIDTH-1:0]   div_r;

  assign Busy = (state == ST_RUN);

  // Launch datapath: results are computed at Start and parked in pend_* until completion.
  // NOTE: every always_comb output gets a default assignment first, so no path can infer a latch.
  always_comb begin
    prod_s     = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
    prod_u     = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
    signed_div = (Op == OP_DIV);
    a_mag      = (signed_div && A[WIDTH-1]) ? -A : A;
    b_mag      = (signed_div && B[WIDTH-1]) ? -B : B;
    b_safe     = (b_mag == '0) ? ONE : b_mag;
    q_mag      = a_mag / b_safe;
    r_mag      = a_mag % b_safe;
    // Magnitude division makes MIN/-1 wrap back to MIN with a zero remainder for free.
    div_q      = (signed_div && (A[WIDTH-1] ^ B[WIDTH-1])) ? -q_mag : q_mag;
    div_r      = (signed_div && A[WIDTH-1]) ? -r_mag : r_mag;
  end

  always_comb begin
    result = {pend_hi, pend_lo};
`ifdef MULDIV_MADD_EN
    if (pend_mode == MODE_ADD) result = {HI, LO} + {pend_hi, pend_lo};
    else if (pend_mode == MODE_SUB) result = {HI, LO} - {pend_hi, pend_lo};
`endif
  end

`ifdef MULDIV_MADD_EN
  always_comb begin
    launch_mode = MODE_SET;
    if (Op == OP_MADD || Op == OP_MADDU) launch_mode = MODE_ADD;
    else if (Op == OP_MSUB || Op == OP_MSUBU) launch_mode = MODE_SUB;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) pend_mode <= MODE_SET;
    else if (state == ST_IDLE && Start) pend_mode <= launch_mode;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= ST_IDLE;
      count      <= '0;
      HI         <= '0;
      LO         <= '0;
      pend_hi    <= '0;
      pend_lo    <= '0;
      pend_write <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (Start) begin
        case (Op)
          OP_MULT, OP_MULTU: begin
            state              <= ST_RUN;
            count              <= MULT_LAT;
            {pend_hi, pend_lo} <= (Op == OP_MULT) ? prod_s : prod_u;
            pend_write         <= 1'b1;
          end
          OP_DIV, OP_DIVU: begin
            state      <= ST_RUN;
            count      <= DIV_LAT;
            pend_hi    <= div_r;
            pend_lo    <= div_q;
            pend_write <= (B != '0);
          end
          OP_MTHI: HI <= A;
          OP_MTLO: LO <= A;
`ifdef MULDIV_MADD_EN
          OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
            state              <= ST_RUN;
            count              <= MULT_LAT;
            {pend_hi, pend_lo} <= (Op == OP_MADD || Op == OP_MSUB) ? prod_s : prod_u;
            pend_write         <= 1'b1;
          end
`endif
          default: ;
        endcase
      end
    end else begin
      if (count == LAST) begin
        state <= ST_IDLE;
        count <= '0;
        if (pend_write) {HI, LO} <= result;
      end else begin
        count <= count - LAST;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, Start-while-Busy, async reset and randomized ops
// against a plain-arithmetic HI/LO model. Follows MULDIV_MADD_EN the same way as the design.
module tb_muldiv_unit;

  localparam int W      = 32;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
`ifdef MULDIV_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           lat;
    logic [W-1:0] want_hi;
    logic [W-1:0] want_lo;
  } vec_t;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         Start;
  logic [3:0]   Op;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Busy;
  logic [W-1:0] HI;
  logic [W-1:0] LO;

  int           total = 0;
  int           bad   = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  muldiv_unit #(.WIDTH(W), .MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: architectural effect of one accepted op on {HI,LO}, plus its Busy length.
  task automatic model_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat);
    logic [63:0] acc;
    logic [63:0] p;
    logic [63:0] qv;
    logic [63:0] rv;
    longint      sa;
    longint      sb;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    acc = {exp_hi, exp_lo};
    lat = 0;
    case (op)
      4'd0: begin p = sa * sb; acc = p; lat = MULT_N; end
      4'd1: begin acc = {32'b0, a} * {32'b0, b}; lat = MULT_N; end
      4'd2: begin
        lat = DIV_N;
        if (b != 0) begin
          qv  = sa / sb;
          rv  = sa % sb;
          acc = {rv[31:0], qv[31:0]};
        end
      end
      4'd3: begin
        lat = DIV_N;
        if (b != 0) acc = {a % b, a / b};
      end
      4'd4: acc[63:32] = a;
      4'd5: acc[31:0]  = a;
      4'd6, 4'd7, 4'd8, 4'd9: begin
        if (MADD_EN) begin
          lat = MULT_N;
          if (op == 4'd6 || op == 4'd8) p = sa * sb;
          else p = {32'b0, a} * {32'b0, b};
          acc = (op <= 4'd7) ? acc + p : acc - p;
        end
      end
      default: ;
    endcase
    {exp_hi, exp_lo} = acc;
  endtask

  // Issue one Start, then count Busy-high cycles. Optionally re-pulse Start on busy cycle 'poke'.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int poke, input logic [3:0] poke_op,
                       output int busy_cyc, output bit early);
    logic [W-1:0] h0;
    logic [W-1:0] l0;
    @(negedge Clk);
    h0 = HI; l0 = LO;
    Start = 1'b1; Op = op; A = a; B = b;
    @(negedge Clk);
    Start = 1'b0; Op = 4'd15;
    busy_cyc = 0; early = 1'b0;
    while (Busy === 1'b1 && busy_cyc < 100) begin
      if (HI !== h0 || LO !== l0) early = 1'b1;
      busy_cyc++;
      if (busy_cyc == poke) begin
        Start = 1'b1; Op = poke_op; A = 32'hDEAD_BEEF; B = 32'h0000_0003;
      end else begin
        Start = 1'b0;
      end
      @(negedge Clk);
    end
    Start = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0; Op = 4'd15; A = '0; B = '0;
    repeat (2) @(negedge Clk);
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", Busy); end
    total++; if (HI !== '0) begin bad++; $display("FAIL reset_hi got=%h want=0", HI); end
    total++; if (LO !== '0) begin bad++; $display("FAIL reset_lo got=%h want=0", LO); end
    Reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
  endtask

  task automatic test_vectors();
    vec_t vecs[5];
    int   lat;
    int   cyc;
    bit   early;
    vecs[0] = '{4'd0, 32'hFFFF_FFFF, 32'h2, MULT_N, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[1] = '{4'd1, 32'hFFFF_FFFF, 32'h2, MULT_N, 32'h0000_0001, 32'hFFFF_FFFE};
    vecs[2] = '{4'd2, 32'hFFFF_FFF9, 32'h2, DIV_N,  32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{4'd3, 32'h7,         32'h0, DIV_N,  32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4] = '{4'd2, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N, 32'h0, 32'h8000_0000};
    for (int i = 0; i < 5; i++) begin
      model_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, 4'd15, cyc, early);
      total++; if (cyc !== vecs[i].lat) begin bad++; $display("FAIL vec%0d_busy got=%0d want=%0d", i, cyc, vecs[i].lat); end
      total++; if (early !== 1'b0) begin bad++; $display("FAIL vec%0d_early got=%b want=0", i, early); end
      total++; if (HI !== vecs[i].want_hi) begin bad++; $display("FAIL vec%0d_hi got=%h want=%h", i, HI, vecs[i].want_hi); end
      total++; if (LO !== vecs[i].want_lo) begin bad++; $display("FAIL vec%0d_lo got=%h want=%h", i, LO, vecs[i].want_lo); end
    end
  endtask

  task automatic test_mt_back_to_back();
    int lat;
    bit busy_seen;
    busy_seen = 1'b0;
    model_op(4'd4, 32'h1234, 32'h0, lat);
    model_op(4'd5, 32'h5678, 32'h0, lat);
    @(negedge Clk);
    Start = 1'b1; Op = 4'd4; A = 32'h1234; B = '0;
    @(negedge Clk);
    if (Busy !== 1'b0) busy_seen = 1'b1;
    total++; if (HI !== 32'h1234) begin bad++; $display("FAIL mthi_hi got=%h want=00001234", HI); end
    Op = 4'd5; A = 32'h5678;
    @(negedge Clk);
    Start = 1'b0; Op = 4'd15;
    if (Busy !== 1'b0) busy_seen = 1'b1;
    total++; if (LO !== 32'h5678) begin bad++; $display("FAIL mtlo_lo got=%h want=00005678", LO); end
    total++; if (HI !== 32'h1234) begin bad++; $display("FAIL mtlo_hi_kept got=%h want=00001234", HI); end
    @(negedge Clk);
    if (Busy !== 1'b0) busy_seen = 1'b1;
    total++; if (busy_seen !== 1'b0) begin bad++; $display("FAIL mt_busy got=%b want=0", busy_seen); end
  endtask

  task automatic test_madd();
    int lat;
    int cyc;
    bit early;
    do_op(4'd4, 32'h0, 32'h0, 0, 4'd15, cyc, early);
    model_op(4'd4, 32'h0, 32'h0, lat);
    do_op(4'd5, 32'hFFFF_FFFF, 32'h0, 0, 4'd15, cyc, early);
    model_op(4'd5, 32'hFFFF_FFFF, 32'h0, lat);
    model_op(4'd7, 32'h1, 32'h1, lat);
    do_op(4'd7, 32'h1, 32'h1, 0, 4'd15, cyc, early);
    total++; if (cyc !== (MADD_EN ? MULT_N : 0)) begin bad++; $display("FAIL maddu_busy got=%0d want=%0d", cyc, MADD_EN ? MULT_N : 0); end
    total++; if (HI !== (MADD_EN ? 32'h1 : 32'h0)) begin bad++; $display("FAIL maddu_hi got=%h", HI); end
    total++; if (LO !== (MADD_EN ? 32'h0 : 32'hFFFF_FFFF)) begin bad++; $display("FAIL maddu_lo got=%h", LO); end
  endtask

  task automatic test_start_while_busy();
    int          lat;
    int          cyc;
    bit          early;
    logic [3:0]  op;
    logic [3:0]  pop;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int          pokes[5];
    pokes = '{1, 4, DIV_N, 2, MULT_N};
    for (int i = 0; i < 5; i++) begin
      op  = (i < 3) ? 4'd2 : 4'd0;
      pop = (i % 2 == 0) ? 4'd4 : 4'd1;
      a   = $urandom; b = $urandom | 32'h1;
      model_op(op, a, b, lat);
      do_op(op, a, b, pokes[i], pop, cyc, early);
      total++; if (cyc !== lat) begin bad++; $display("FAIL ignore%0d_busy got=%0d want=%0d", i, cyc, lat); end
      total++; if (HI !== exp_hi || LO !== exp_lo) begin bad++; $display("FAIL ignore%0d_hilo got=%h_%h want=%h_%h", i, HI, LO, exp_hi, exp_lo); end
      @(negedge Clk);
      total++; if (Busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin bad++; $display("FAIL ignore%0d_after got busy=%b %h_%h want busy=0 %h_%h", i, Busy, HI, LO, exp_hi, exp_lo); end
    end
  endtask

  task automatic test_reset_mid_div();
    int lat;
    int cyc;
    bit early;
    int busy_after;
    do_op(4'd4, 32'hAAAA_5555, 32'h0, 0, 4'd15, cyc, early);
    do_op(4'd5, 32'h1357_9BDF, 32'h0, 0, 4'd15, cyc, early);
    @(negedge Clk);
    Start = 1'b1; Op = 4'd2; A = 32'd100; B = 32'd7;
    @(negedge Clk);
    Start = 1'b0; Op = 4'd15;
    repeat (3) @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL async_rst_busy got=%b want=0", Busy); end
    total++; if (HI !== '0 || LO !== '0) begin bad++; $display("FAIL async_rst_hilo got=%h_%h want=0_0", HI, LO); end
    @(negedge Clk);
    Reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    busy_after = 0;
    repeat (DIV_N + 3) begin
      @(negedge Clk);
      if (Busy !== 1'b0) busy_after++;
    end
    total++; if (busy_after !== 0) begin bad++; $display("FAIL post_rst_busy got=%0d want=0", busy_after); end
    total++; if (HI !== '0 || LO !== '0) begin bad++; $display("FAIL post_rst_stale got=%h_%h want=0_0", HI, LO); end
    model_op(4'd15, 32'h0, 32'h0, lat);
  endtask

  task automatic test_random();
    int           lat;
    int           cyc;
    bit           early;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 9) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      model_op(op, a, b, lat);
      do_op(op, a, b, 0, 4'd15, cyc, early);
      total++; if (cyc !== lat) begin bad++; $display("FAIL rand%0d_op%0d_busy got=%0d want=%0d", i, op, cyc, lat); end
      total++; if (early !== 1'b0) begin bad++; $display("FAIL rand%0d_op%0d_early got=%b want=0", i, op, early); end
      total++; if (HI !== exp_hi) begin bad++; $display("FAIL rand%0d_op%0d_hi got=%h want=%h a=%h b=%h", i, op, HI, exp_hi, a, b); end
      total++; if (LO !== exp_lo) begin bad++; $display("FAIL rand%0d_op%0d_lo got=%h want=%h a=%h b=%h", i, op, LO, exp_lo, a, b); end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_mt_back_to_back();
    test_madd();
    test_start_while_busy();
    test_reset_mid_div();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
